// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage buffer: circular FIFO with flush and occupancy count.
// Define PIPE_BUF_BYPASS_EN for a zero-latency bypass when the buffer is empty.
module pipe_stage_buf #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty;
  logic              push;
  logic              pop;

  // Handshake decode and next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    empty     = (count_q == '0);
    in_ready  = (count_q < CNT_W'(DEPTH));
`ifdef PIPE_BUF_BYPASS_EN
    out_valid = (!empty || in_valid) && !flush;
    out_data  = empty ? in_data : mem_q[rd_ptr_q];
    // A bypassed payload taken downstream this cycle never lands in storage.
    push      = in_valid && in_ready && !flush && !(empty && out_ready);
`else
    out_valid = !empty && !flush;
    out_data  = mem_q[rd_ptr_q];
    push      = in_valid && in_ready && !flush;
`endif
    pop       = !empty && out_valid && out_ready;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is not reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign count = count_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: DEPTH=2 and DEPTH=4 instances.
// Bypass checks run only when PIPE_BUF_BYPASS_EN is defined.
module tb_pipe_stage_buf;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
  logic [63:0] a_in_data, a_out_data;
  logic [1:0]  a_count;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
  logic [63:0] b_in_data, b_out_data;
  logic [2:0]  b_count;

  logic [63:0] sb_a [$];
  logic [63:0] sb_b [$];
  logic [63:0] exp_v;
  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_buf #(.DATA_W(64), .DEPTH(2)) u_d2 (
    .clk(clk), .reset(rst), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_ready(a_out_ready), .flush(a_flush), .count(a_count));

  pipe_stage_buf #(.DATA_W(64), .DEPTH(4)) u_d4 (
    .clk(clk), .reset(rst), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_ready(b_out_ready), .flush(b_flush), .count(b_count));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b1;
    a_in_valid = 0; a_in_data = '0; a_out_ready = 0; a_flush = 0;
    b_in_valid = 0; b_in_data = '0; b_out_ready = 0; b_flush = 0;
    #13;
    n_checks++; if (a_count !== 2'd0) begin n_fail++; $display("FAIL reset_count_a: got %0d expected 0", a_count); end
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_a: got %b expected 0", a_out_valid); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_a: got %b expected 1", a_in_ready); end
    n_checks++; if (b_count !== 3'd0) begin n_fail++; $display("FAIL reset_count_b: got %0d expected 0", b_count); end
    n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_b: got %b expected 1", b_in_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Push 0xA, 0xB with no consumer: fills DEPTH=2 and head must hold.
  task automatic test_fill_hold();
    a_in_valid = 1; a_in_data = 64'hA; a_out_ready = 0;
    #1;
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_first_ready: got %b expected 1", a_in_ready); end
    if (a_in_ready) sb_a.push_back(a_in_data);
    @(negedge clk);
    a_in_data = 64'hB;
    #1;
    n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL fill_latency_valid: got %b expected 1", a_out_valid); end
    n_checks++; if (a_out_data !== sb_a[0]) begin n_fail++; $display("FAIL fill_head_data: got %0h expected %0h", a_out_data, sb_a[0]); end
    if (a_in_ready) sb_a.push_back(a_in_data);
    @(negedge clk);
    a_in_valid = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (a_count !== 2'd2) begin n_fail++; $display("FAIL fill_count: got %0d expected 2", a_count); end
      n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready: got %b expected 0", a_in_ready); end
      n_checks++; if (a_out_data !== 64'hA) begin n_fail++; $display("FAIL fill_hold_data: got %0h expected a", a_out_data); end
      @(negedge clk);
    end
  endtask

  // Full buffer: offer 0xC while popping; 0xC must be rejected.
  task automatic test_full_pop();
    a_in_valid = 1; a_in_data = 64'hC; a_out_ready = 1;
    #1;
    n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_in_ready: got %b expected 0", a_in_ready); end
    if (a_in_ready) sb_a.push_back(a_in_data);
    n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL full_pop_valid: got %b expected 1", a_out_valid); end
    exp_v = sb_a.pop_front();
    n_checks++; if (a_out_data !== exp_v) begin n_fail++; $display("FAIL full_pop_data: got %0h expected %0h", a_out_data, exp_v); end
    @(negedge clk);
    a_in_valid = 0; a_out_ready = 0;
    #1;
    n_checks++; if (a_count !== 2'd1) begin n_fail++; $display("FAIL full_pop_count: got %0d expected 1", a_count); end
    n_checks++; if (a_out_data !== sb_a[0]) begin n_fail++; $display("FAIL full_pop_next: got %0h expected %0h", a_out_data, sb_a[0]); end
    a_out_ready = 1;
    exp_v = sb_a.pop_front();
    @(negedge clk);
    a_out_ready = 0;
    #1;
    n_checks++; if (a_count !== 2'd0) begin n_fail++; $display("FAIL full_pop_drain_count: got %0d expected 0", a_count); end
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL full_pop_drain_valid: got %b expected 0", a_out_valid); end
    @(negedge clk);
  endtask

  // DEPTH=4: values 1..10 with random push/pop interleave across pointer wraps.
  task automatic test_fifo_wrap();
    int nxt = 1;
    int got = 0;
    int s0;
    logic exp_ov;
    for (int cyc = 0; cyc < 400 && got < 10; cyc++) begin
      b_in_valid  = (nxt <= 10) && ($urandom_range(0, 2) != 0);
      b_in_data   = 64'(nxt);
      b_out_ready = ($urandom_range(0, 1) != 0);
      #1;
      s0 = sb_b.size();
      exp_ov = (s0 != 0);
`ifdef PIPE_BUF_BYPASS_EN
      exp_ov = exp_ov || b_in_valid;
`endif
      n_checks++; if (b_count !== 3'(s0)) begin n_fail++; $display("FAIL wrap_count: got %0d expected %0d", b_count, s0); end
      n_checks++; if (b_in_ready !== (s0 < 4)) begin n_fail++; $display("FAIL wrap_in_ready: got %b expected %b", b_in_ready, s0 < 4); end
      n_checks++; if (b_out_valid !== exp_ov) begin n_fail++; $display("FAIL wrap_out_valid: got %b expected %b", b_out_valid, exp_ov); end
      if (b_in_valid && b_in_ready) begin
        sb_b.push_back(b_in_data);
        nxt++;
      end
      if (b_out_valid && b_out_ready) begin
        n_checks++;
        if (sb_b.size() == 0) begin
          n_fail++; $display("FAIL wrap_pop_empty: got data %0h expected no output", b_out_data);
        end else begin
          exp_v = sb_b.pop_front();
          if (b_out_data !== exp_v) begin n_fail++; $display("FAIL wrap_order: got %0h expected %0h", b_out_data, exp_v); end
          got++;
        end
      end
      @(negedge clk);
    end
    b_in_valid = 0; b_out_ready = 0;
    n_checks++; if (got != 10) begin n_fail++; $display("FAIL wrap_complete: got %0d outputs expected 10", got); end
  endtask

  // Three entries, then flush with an input offered: everything discarded.
  task automatic test_flush();
    b_out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      b_in_valid = 1; b_in_data = 64'(8'h11 + i);
      @(negedge clk);
    end
    b_in_valid = 0;
    #1;
    n_checks++; if (b_count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count: got %0d expected 3", b_count); end
    b_in_valid = 1; b_in_data = 64'h99; b_flush = 1; b_out_ready = 1;
    #1;
    n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b expected 0", b_out_valid); end
    @(negedge clk);
    b_flush = 0; b_in_valid = 0; b_out_ready = 0;
    #1;
    n_checks++; if (b_count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", b_count); end
    n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_after_valid: got %b expected 0", b_out_valid); end
    sb_b.delete();
    b_in_valid = 1; b_in_data = 64'h21;
    sb_b.push_back(b_in_data);
    @(negedge clk);
    b_in_valid = 0;
    #1;
    n_checks++; if (b_count !== 3'd1) begin n_fail++; $display("FAIL flush_refill_count: got %0d expected 1", b_count); end
    n_checks++; if (b_out_data !== sb_b[0]) begin n_fail++; $display("FAIL flush_refill_data: got %0h expected %0h", b_out_data, sb_b[0]); end
    b_out_ready = 1;
    exp_v = sb_b.pop_front();
    @(negedge clk);
    b_out_ready = 0;
  endtask

  // Reset asserted between edges at count=2 must clear immediately.
  task automatic test_async_reset();
    a_out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      a_in_valid = 1; a_in_data = 64'(8'h31 + i);
      @(negedge clk);
    end
    a_in_valid = 0;
    #1;
    n_checks++; if (a_count !== 2'd2) begin n_fail++; $display("FAIL areset_pre_count: got %0d expected 2", a_count); end
    #1;
    rst = 1'b1;
    #1;
    n_checks++; if (a_count !== 2'd0) begin n_fail++; $display("FAIL areset_count: got %0d expected 0", a_count); end
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_out_valid: got %b expected 0", a_out_valid); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL areset_in_ready: got %b expected 1", a_in_ready); end
    sb_a.delete();
    @(negedge clk);
    rst = 1'b0;
    a_in_valid = 1; a_in_data = 64'h41;
    sb_a.push_back(a_in_data);
    @(negedge clk);
    a_in_valid = 0;
    #1;
    n_checks++; if (a_count !== 2'd1) begin n_fail++; $display("FAIL post_reset_push_count: got %0d expected 1", a_count); end
    n_checks++; if (a_out_data !== sb_a[0]) begin n_fail++; $display("FAIL post_reset_push_data: got %0h expected %0h", a_out_data, sb_a[0]); end
    a_out_ready = 1;
    exp_v = sb_a.pop_front();
    @(negedge clk);
    a_out_ready = 0;
  endtask

`ifdef PIPE_BUF_BYPASS_EN
  task automatic test_bypass();
    a_in_valid = 1; a_in_data = 64'h55; a_out_ready = 1;
    #1;
    n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL bypass_valid: got %b expected 1", a_out_valid); end
    n_checks++; if (a_out_data !== 64'h55) begin n_fail++; $display("FAIL bypass_data: got %0h expected 55", a_out_data); end
    @(negedge clk);
    a_in_valid = 0; a_out_ready = 0;
    #1;
    n_checks++; if (a_count !== 2'd0) begin n_fail++; $display("FAIL bypass_count: got %0d expected 0", a_count); end
    a_in_valid = 1; a_in_data = 64'h66;
    @(negedge clk);
    a_in_valid = 0;
    #1;
    n_checks++; if (a_count !== 2'd1) begin n_fail++; $display("FAIL bypass_store_count: got %0d expected 1", a_count); end
    n_checks++; if (a_out_data !== 64'h66) begin n_fail++; $display("FAIL bypass_store_data: got %0h expected 66", a_out_data); end
    a_out_ready = 1;
    @(negedge clk);
    a_out_ready = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_fill_hold();
    test_full_pop();
    test_fifo_wrap();
    test_flush();
    test_async_reset();
`ifdef PIPE_BUF_BYPASS_EN
    test_bypass();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
